// File: rtl/rtc_seg_display_if.sv
// rtc_seg_display_if: BCD time inputs and display drive outputs
// master = time source / display, slave = the display driver
interface rtc_seg_display_if;
  logic [7:0] Time_second;
  logic [7:0] Time_munite;
  logic [7:0] Time_hour;
  logic [7:0] Seg_Out;
  logic [5:0] Sel_Out;
  logic       Bcd_Err;

  modport master (
    output Time_second,
    output Time_munite,
    output Time_hour,
    input  Seg_Out,
    input  Sel_Out,
    input  Bcd_Err
  );

  modport slave (
    input  Time_second,
    input  Time_munite,
    input  Time_hour,
    output Seg_Out,
    output Sel_Out,
    output Bcd_Err
  );
endinterface

// File: rtl/rtc_seg_display.sv
// rtc_seg_display: 6-digit HH.MM.SS multiplexed 7-seg driver
// frame-synchronous BCD snapshot, blinking separators
module rtc_seg_display #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int LZ_BLANK  = 1
) (
  input  logic             CLK,
  input  logic             RSTn,
  rtc_seg_display_if.slave bus
);

  localparam int PW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST =
    PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLK =
    PW'(BLANK_CYC);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [7:0]    r_hr;
  logic [7:0]    r_mn;
  logic [7:0]    r_sc;
  logic          r_err;
  logic [7:0]    r_seg;
  logic [5:0]    r_sel;

  logic          w_slot_end;
  logic          w_frame_end;
  logic          w_blank;
  logic          w_valid;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg7;
  logic          w_dp;
  logic [7:0]    w_code;
  logic [5:0]    w_sel;

  // slot / frame boundaries and anti-ghost window
  always_comb begin
    w_slot_end  = (r_presc == LAST);
    w_frame_end = w_slot_end && (r_idx == 3'd5);
    w_blank     = (r_presc < BLK);
  end

  // accept a snapshot only if every field is legal BCD time
  always_comb begin
    w_valid =
      (bus.Time_second[3:0] <= 4'd9) &&
      (bus.Time_second[7:4] <= 4'd5) &&
      (bus.Time_munite[3:0] <= 4'd9) &&
      (bus.Time_munite[7:4] <= 4'd5) &&
      (bus.Time_hour[3:0]   <= 4'd9) &&
      (bus.Time_hour[7:4]   <= 4'd9) &&
      (bus.Time_hour        <= 8'h23);
  end

  // pick the nibble shown in the current slot
  always_comb begin
    w_nib = r_sc[3:0];
    unique case (1'b1)
      r_idx == 3'd0: w_nib = r_hr[7:4];
      r_idx == 3'd1: w_nib = r_hr[3:0];
      r_idx == 3'd2: w_nib = r_mn[7:4];
      r_idx == 3'd3: w_nib = r_mn[3:0];
      r_idx == 3'd4: w_nib = r_sc[7:4];
      default:       w_nib = r_sc[3:0];
    endcase
  end

  // active-low glyph, separator dp and leading-zero blank
  always_comb begin
    unique case (w_nib)
      4'd0:    w_seg7 = 7'h40;
      4'd1:    w_seg7 = 7'h79;
      4'd2:    w_seg7 = 7'h24;
      4'd3:    w_seg7 = 7'h30;
      4'd4:    w_seg7 = 7'h19;
      4'd5:    w_seg7 = 7'h12;
      4'd6:    w_seg7 = 7'h02;
      4'd7:    w_seg7 = 7'h78;
      4'd8:    w_seg7 = 7'h00;
      4'd9:    w_seg7 = 7'h10;
      default: w_seg7 = 7'h7F;
    endcase
    w_dp = !(((r_idx == 3'd1) ||
              (r_idx == 3'd3)) &&
             !r_sc[0]);
    if ((LZ_BLANK != 0) &&
        (r_idx == 3'd0) &&
        (r_hr[7:4] == 4'd0))
      w_code = 8'hFF;
    else
      w_code = {w_dp, w_seg7};
    w_sel = ~(6'b1 << r_idx);
  end

  // scan counters, frame snapshot and registered drive
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_presc <= '0;
      r_idx   <= 3'd0;
      r_hr    <= 8'h00;
      r_mn    <= 8'h00;
      r_sc    <= 8'h00;
      r_err   <= 1'b0;
      r_seg   <= 8'hFF;
      r_sel   <= 6'h3F;
    end else begin
      r_presc <= w_slot_end ? '0
                            : r_presc + 1'b1;
      if (w_slot_end)
        r_idx <= (r_idx == 3'd5) ? 3'd0
                                 : r_idx + 3'd1;
      if (w_frame_end) begin
        if (w_valid) begin
          r_hr <= bus.Time_hour;
          r_mn <= bus.Time_munite;
          r_sc <= bus.Time_second;
        end else begin
          r_err <= 1'b1;
        end
      end
      r_seg <= w_blank ? 8'hFF : w_code;
      r_sel <= w_blank ? 6'h3F : w_sel;
    end
  end

  assign bus.Seg_Out = r_seg;
  assign bus.Sel_Out = r_sel;
  assign bus.Bcd_Err = r_err;

endmodule

// File: tb/tb_rtc_seg_display.sv
// tb_rtc_seg_display: vector table, corner sequences and
// randomized inputs against a cycle-count reference model
module tb_rtc_seg_display;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = 6 * SD;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rtc_seg_display_if u_if ();

  rtc_seg_display #(
    .SCAN_DIV (SD),
    .BLANK_CYC(BC),
    .LZ_BLANK (1)
  ) dut (
    .CLK (clk),
    .RSTn(rstn),
    .bus (u_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  int         m_cnt;
  logic [7:0] m_hr, m_mn, m_sc;
  logic       m_err;
  logic [7:0] e_seg;
  logic [5:0] e_sel;

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [7:0] glyph(int v);
    logic [7:0] t [10];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return t[v];
  endfunction

  function automatic bit time_ok(logic [7:0] h,
                                 logic [7:0] m,
                                 logic [7:0] s);
    int ht, hu, mt, mu, st, su;
    ht = int'(h[7:4]); hu = int'(h[3:0]);
    mt = int'(m[7:4]); mu = int'(m[3:0]);
    st = int'(s[7:4]); su = int'(s[3:0]);
    return ht <= 9 && hu <= 9 &&
           ht * 10 + hu <= 23 &&
           mt <= 5 && mu <= 9 &&
           st <= 5 && su <= 9;
  endfunction

  function automatic logic [5:0] ref_sel(int c);
    logic [5:0] s;
    int p, d;
    p = c % SD;
    d = (c / SD) % 6;
    s = 6'h3F;
    if (p >= BC) s[d] = 1'b0;
    return s;
  endfunction

  function automatic logic [7:0] ref_seg(
      int c, logic [7:0] h,
      logic [7:0] m, logic [7:0] s);
    int p, d;
    int digs[6];
    logic [7:0] g;
    p = c % SD;
    d = (c / SD) % 6;
    digs = '{int'(h[7:4]), int'(h[3:0]),
             int'(m[7:4]), int'(m[3:0]),
             int'(s[7:4]), int'(s[3:0])};
    if (p < BC) return 8'hFF;
    if (d == 0 && digs[0] == 0) return 8'hFF;
    g = glyph(digs[d]);
    if ((d == 1 || d == 3) && digs[5] % 2 == 0)
      g[7] = 1'b0;
    return g;
  endfunction

  // reference: outputs follow the edge count since reset
  always @(posedge clk) begin
    if (!rstn) begin
      m_cnt <= 0;
      m_hr  <= 8'h00;
      m_mn  <= 8'h00;
      m_sc  <= 8'h00;
      m_err <= 1'b0;
      e_seg <= 8'hFF;
      e_sel <= 6'h3F;
    end else begin
      e_seg <= ref_seg(m_cnt, m_hr, m_mn, m_sc);
      e_sel <= ref_sel(m_cnt);
      if (m_cnt % FR == FR - 1) begin
        if (time_ok(u_if.Time_hour,
                    u_if.Time_munite,
                    u_if.Time_second)) begin
          m_hr <= u_if.Time_hour;
          m_mn <= u_if.Time_munite;
          m_sc <= u_if.Time_second;
        end else begin
          m_err <= 1'b1;
        end
      end
      m_cnt <= m_cnt + 1;
    end
  end

  // continuous comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_seg", 32'(u_if.Seg_Out), 32'(e_seg));
      chk("model_sel", 32'(u_if.Sel_Out), 32'(e_sel));
      chk("model_err", 32'(u_if.Bcd_Err), 32'(m_err));
    end
  end

  task automatic goto(int tgt);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (m_cnt % FR != tgt && k < 200);
    if (m_cnt % FR != tgt) begin
      n_tests++;
      n_fail++;
      $display("FAIL goto_timeout: got %0d expected %0d",
               m_cnt % FR, tgt);
    end
  endtask

  task automatic set_time(logic [7:0] h,
                          logic [7:0] m,
                          logic [7:0] s);
    u_if.Time_hour   = h;
    u_if.Time_munite = m;
    u_if.Time_second = s;
  endtask

  function automatic logic [7:0] rbcd(int mx);
    int v;
    v = $urandom_range(0, mx);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  typedef struct {
    logic [7:0]           h;
    logic [7:0]           m;
    logic [7:0]           s;
    logic [0:5][7:0]      segs;
  } vec_t;

  vec_t tab[6];
  int   cnt[6];

  initial begin
    tab[0] = '{8'h12, 8'h49, 8'h07,
      {8'hF9, 8'hA4, 8'h99, 8'h90, 8'hC0, 8'hF8}};
    tab[1] = '{8'h07, 8'h30, 8'h08,
      {8'hFF, 8'h78, 8'hB0, 8'h40, 8'hC0, 8'h80}};
    tab[2] = '{8'h07, 8'h30, 8'h09,
      {8'hFF, 8'hF8, 8'hB0, 8'hC0, 8'hC0, 8'h90}};
    tab[3] = '{8'h23, 8'h59, 8'h58,
      {8'hA4, 8'h30, 8'h92, 8'h10, 8'h92, 8'h80}};
    tab[4] = '{8'h20, 8'h05, 8'h01,
      {8'hA4, 8'hC0, 8'hC0, 8'h92, 8'hC0, 8'hF9}};
    tab[5] = '{8'h10, 8'h00, 8'h00,
      {8'hF9, 8'h40, 8'hC0, 8'h40, 8'hC0, 8'hC0}};

    // reset
    set_time(8'h00, 8'h00, 8'h00);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_seg", 32'(u_if.Seg_Out), 32'hFF);
    chk("rst_sel", 32'(u_if.Sel_Out), 32'h3F);
    chk("rst_err", 32'(u_if.Bcd_Err), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    rstn   = 1'b1;
    goto(2);
    chk("first_blank", 32'(u_if.Sel_Out), 32'h3F);
    goto(3);
    chk("first_sel", 32'(u_if.Sel_Out), 32'h3E);
    chk("lz_zero", 32'(u_if.Seg_Out), 32'hFF);
    goto(14);
    chk("d1_sel", 32'(u_if.Sel_Out), 32'h3D);
    chk("d1_zero", 32'(u_if.Seg_Out), 32'h40);

    // vector table
    for (int i = 0; i < 6; i++) begin
      goto(0);
      set_time(tab[i].h, tab[i].m, tab[i].s);
      goto(0);
      for (int d = 0; d < 6; d++) begin
        goto(8 * d + 6);
        chk($sformatf("v%0d_sel%0d", i, d),
            32'(u_if.Sel_Out),
            32'(6'h3F & ~(6'd1 << d)));
        chk($sformatf("v%0d_seg%0d", i, d),
            32'(u_if.Seg_Out),
            32'(tab[i].segs[d]));
      end
      chk($sformatf("v%0d_err", i),
          32'(u_if.Bcd_Err), 32'h0);
    end

    // select low time per frame
    goto(0);
    for (int d = 0; d < 6; d++) cnt[d] = 0;
    for (int k = 0; k < FR; k++) begin
      @(negedge clk);
      for (int d = 0; d < 6; d++)
        if (!u_if.Sel_Out[d]) cnt[d]++;
    end
    for (int d = 0; d < 6; d++)
      chk($sformatf("sel_len%0d", d),
          32'(cnt[d]), 32'(SD - BC));

    // invalid input keeps old snapshot
    goto(0);
    set_time(8'h12, 8'h49, 8'h07);
    goto(0);
    set_time(8'h12, 8'h49, 8'h5A);
    goto(0);
    chk("bad_err", 32'(u_if.Bcd_Err), 32'h1);
    goto(46);
    chk("bad_hold", 32'(u_if.Seg_Out), 32'hF8);
    set_time(8'h12, 8'h49, 8'h33);
    goto(0);
    goto(46);
    chk("fix_seg", 32'(u_if.Seg_Out), 32'hB0);
    chk("fix_err", 32'(u_if.Bcd_Err), 32'h1);

    // reset in the middle of slot 3
    goto(29);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_seg", 32'(u_if.Seg_Out), 32'hFF);
    chk("mid_sel", 32'(u_if.Sel_Out), 32'h3F);
    chk("mid_err", 32'(u_if.Bcd_Err), 32'h0);
    rstn = 1'b1;
    goto(2);
    chk("mid_blank", 32'(u_if.Sel_Out), 32'h3F);
    goto(3);
    chk("mid_sel0", 32'(u_if.Sel_Out), 32'h3E);

    // randomized inputs at random points
    for (int f = 0; f < 30; f++) begin
      goto($urandom_range(0, FR - 1));
      if ($urandom_range(0, 3) == 0)
        set_time(8'($urandom), 8'($urandom),
                 8'($urandom));
      else
        set_time(rbcd(23), rbcd(59), rbcd(59));
    end
    goto(0);
    goto(0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
